// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one local command into one AXI
// read or write and returns the response, flagging handshakes that wait too long.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  logic [2:0]            state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [15:0]           wait_cnt, wait_next;
  logic                  timeout_flag, timeout_next;
  logic                  aw_hs, w_hs, ar_hs, r_hs, b_hs, any_hs;
  logic                  cmd_accept, waiting;

  // Payload outputs come straight from the command capture registers, so they
  // are registered and cannot change while any valid is high.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign ar_hs      = m_axi_arvalid & m_axi_arready;
  assign r_hs       = m_axi_rvalid & m_axi_rready;
  assign b_hs       = m_axi_bvalid & m_axi_bready;
  assign any_hs     = aw_hs | w_hs | ar_hs | r_hs | b_hs;
  assign cmd_accept = cmd_valid & cmd_ready;
  assign waiting    = (state == WR_REQ) || (state == WR_RESP) ||
                      (state == RD_REQ) || (state == RD_DATA);

  // In WR_REQ a channel whose valid has already dropped is finished.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_accept) next_state = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!m_axi_awvalid || aw_hs) && (!m_axi_wvalid || w_hs))
                 next_state = WR_RESP;
      WR_RESP: if (b_hs) next_state = RSP;
      RD_REQ:  if (ar_hs) next_state = RD_DATA;
      RD_DATA: if (r_hs) next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wait_next = wait_cnt;
    if ((next_state != state) || any_hs)
      wait_next = '0;
    else if (waiting && (wait_cnt != 16'hFFFF))
      wait_next = wait_cnt + 16'd1;
  end

  always_comb begin
    timeout_next = timeout_flag;
    if (cmd_accept)
      timeout_next = 1'b0;
    else if (wait_cnt > LIMIT)
      timeout_next = 1'b1;
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wait_cnt      <= '0;
      timeout_flag  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      state        <= next_state;
      cmd_ready    <= (next_state == IDLE);
      wait_cnt     <= wait_next;
      timeout_flag <= timeout_next;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            wstrb_q       <= cmd_wstrb;
            m_axi_awvalid <= cmd_write;
            m_axi_wvalid  <= cmd_write;
            m_axi_arvalid <= ~cmd_write;
          end
        end
        WR_REQ: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          if (next_state == WR_RESP) m_axi_bready <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= timeout_next;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            rsp_timeout  <= timeout_next;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
